// File: rtl/arithm_pkg.sv
// Shared mode encodings for the arithm_mac pipeline.
package arithm_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_MAC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/arithm_stage.sv
// Pipeline stage register with valid bit; payload only loads on a valid beat
// so it holds its last value across bubbles.
module arithm_stage #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  output logic [N-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ce) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/arithm_mac.sv
// Three-stage (a+/-b)*c pipeline with a guarded, overflow-tracking accumulator.
module arithm_mac
  import arithm_pkg::*;
#(
  parameter int unsigned W     = 14,
  parameter int unsigned GUARD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [1:0]         mode,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [W-1:0]       c,
  output logic               out_valid,
  output logic [2*W:0]       o,
  output logic [2*W+GUARD:0] acc,
  output logic               ovf
);

  localparam int unsigned PW    = 2 * W + 1;
  localparam int unsigned ACC_W = PW + GUARD;
  localparam int unsigned DW    = PW + 2;

  logic signed [W:0]       s1_c;
  logic [DW-1:0]           d0_c;
  logic                    valid1;
  logic [DW-1:0]           d1;
  logic signed [W:0]       s1_s;
  logic signed [W-1:0]     c1_s;
  logic signed [PW-1:0]    p2_c;
  logic [DW-1:0]           d1p_c;
  logic                    valid2;
  logic [DW-1:0]           d2;
  logic signed [PW-1:0]    p2_s;
  logic [1:0]              mode2;
  logic signed [ACC_W-1:0] p2_ext;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;

  // Stage 1 operand: sign-extend before add/sub so nothing is lost.
  always_comb begin
    if (mode == MODE_SUB) s1_c = $signed({a[W-1], a}) - $signed({b[W-1], b});
    else                  s1_c = $signed({a[W-1], a}) + $signed({b[W-1], b});
    d0_c = {mode, c, s1_c};
  end

  arithm_stage #(.N(DW)) u_stage1 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .in_data(d0_c),
    .out_valid(valid1), .out_data(d1)
  );

  always_comb begin
    s1_s  = $signed(d1[W:0]);
    c1_s  = $signed(d1[2*W:W+1]);
    p2_c  = PW'(s1_s) * PW'(c1_s);
    d1p_c = {d1[DW-1:DW-2], p2_c};
  end

  arithm_stage #(.N(DW)) u_stage2 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(valid1), .in_data(d1p_c),
    .out_valid(valid2), .out_data(d2)
  );

  arithm_stage #(.N(PW)) u_stage3 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(valid2), .in_data(d2[PW-1:0]),
    .out_valid(out_valid), .out_data(o)
  );

  // Accumulator retires alongside stage 3; overflow is judged on operand/result signs.
  always_comb begin
    p2_s   = $signed(d2[PW-1:0]);
    mode2  = d2[DW-1:DW-2];
    p2_ext = ACC_W'(p2_s);
    sum_c  = acc_q + p2_ext;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    if (ce && valid2) begin
      case (mode2)
        MODE_MAC: begin
          acc_d = sum_c;
          if ((acc_q[ACC_W-1] == p2_ext[ACC_W-1]) && (sum_c[ACC_W-1] != acc_q[ACC_W-1]))
            ovf_d = 1'b1;
        end
        MODE_LOAD: begin
          acc_d = p2_ext;
          ovf_d = 1'b0;
        end
        MODE_ADD, MODE_SUB: acc_d = acc_q;
        default:            acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_arithm_mac.sv
// Directed self-checking bench for arithm_mac (default and GUARD=0 instances).
module tb_arithm_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [13:0] a = '0, b = '0, c = '0;

  logic        ov0, ovf0, ov1, ovf1;
  logic [28:0] o0, o1;
  logic [32:0] acc0;
  logic [28:0] acc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arithm_mac #(.W(14), .GUARD(4)) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
    .a(a), .b(b), .c(c), .out_valid(ov0), .o(o0), .acc(acc0), .ovf(ovf0)
  );

  arithm_mac #(.W(14), .GUARD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
    .a(a), .b(b), .c(c), .out_valid(ov1), .o(o1), .acc(acc1), .ovf(ovf1)
  );

  task automatic step(input logic ce_i, input logic rst_i, input logic v_i,
                      input logic [1:0] m_i, input int a_i, input int b_i, input int c_i);
    ce       = ce_i;
    rst_n    = rst_i;
    in_valid = v_i;
    mode     = m_i;
    a        = 14'(a_i);
    b        = 14'(b_i);
    c        = 14'(c_i);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 2'b00, 0, 0, 0);
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with ce low must still clear everything
    step(1'b0, 1'b0, 1'b1, 2'b11, 5, 5, 5);
    step(1'b0, 1'b0, 1'b1, 2'b11, 5, 5, 5);
    chk("rst_out_valid", ov0, 0);
    chk("rst_o", $signed(o0), 0);
    chk("rst_acc", $signed(acc0), 0);
    chk("rst_ovf", ovf0, 0);

    // Basic latency: (100-30)*7 = 490
    step(1'b1, 1'b1, 1'b1, 2'b00, 100, -30, 7);
    idle();
    chk("lat_early_valid", ov0, 0);
    idle();
    chk("lat_valid", ov0, 1);
    chk("lat_o", $signed(o0), 490);
    chk("lat_acc", $signed(acc0), 0);
    idle();
    chk("bubble_valid", ov0, 0);
    chk("bubble_hold_o", $signed(o0), 490);

    // Extremes back-to-back
    step(1'b1, 1'b1, 1'b1, 2'b00, -8192, -8192, -8192);
    step(1'b1, 1'b1, 1'b1, 2'b01, -8192, 8191, 8191);
    idle();
    chk("ext_add_valid", ov0, 1);
    chk("ext_add_o", $signed(o0), 134217728);
    idle();
    chk("ext_sub_valid", ov0, 1);
    chk("ext_sub_o", $signed(o0), -134193153);

    // MAC sequence, then bubbles carrying MAC/LOAD mode fields
    step(1'b1, 1'b1, 1'b1, 2'b11, 1, 2, 3);
    step(1'b1, 1'b1, 1'b1, 2'b10, 4, -1, 5);
    step(1'b1, 1'b1, 1'b1, 2'b10, 0, 0, 9);
    chk("mac_acc0", $signed(acc0), 9);
    step(1'b1, 1'b1, 1'b1, 2'b10, -2, -3, 2);
    chk("mac_acc1", $signed(acc0), 24);
    step(1'b1, 1'b1, 1'b0, 2'b10, 100, 100, 100);
    chk("mac_acc2", $signed(acc0), 24);
    step(1'b1, 1'b1, 1'b0, 2'b10, 100, 100, 100);
    chk("mac_acc3", $signed(acc0), 14);
    chk("mac_o3", $signed(o0), -10);
    chk("mac_ovf", ovf0, 0);
    step(1'b1, 1'b1, 1'b0, 2'b11, 7, 7, 7);
    step(1'b1, 1'b1, 1'b0, 2'b11, 7, 7, 7);
    chk("bubble_acc", $signed(acc0), 14);

    // Overflow on the GUARD=0 instance
    step(1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 2'b11, -8192, -8192, -8192);
    step(1'b1, 1'b1, 1'b1, 2'b10, -8192, -8192, -8192);
    step(1'b1, 1'b1, 1'b1, 2'b00, 1, 1, 1);
    chk("ovf_load_acc", $signed(acc1), 134217728);
    chk("ovf_load_flag", ovf1, 0);
    step(1'b1, 1'b1, 1'b1, 2'b11, 1, 0, 1);
    chk("ovf_wrap_acc", $signed(acc1), -268435456);
    chk("ovf_set", ovf1, 1);
    chk("guard_acc", $signed(acc0), 268435456);
    chk("guard_ovf", ovf0, 0);
    idle();
    chk("ovf_sticky", ovf1, 1);
    chk("ovf_sticky_acc", $signed(acc1), -268435456);
    chk("ovf_mode00_o", $signed(o1), 2);
    idle();
    chk("ovf_clear_acc", $signed(acc1), 1);
    chk("ovf_clear", ovf1, 0);
    idle();

    // Stall: ce low for 4 cycles after the second accept, junk inputs ignored
    step(1'b1, 1'b1, 1'b1, 2'b00, 1, 2, 3);
    step(1'b1, 1'b1, 1'b1, 2'b00, 2, 2, 2);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 2'b11, 50, 50, 50);
      chk("stall_no_valid", ov0, 0);
    end
    step(1'b1, 1'b1, 1'b1, 2'b00, -1, 0, 5);
    chk("stall_r0_valid", ov0, 1);
    chk("stall_r0_o", $signed(o0), 9);
    idle();
    chk("stall_r1_o", $signed(o0), 8);
    idle();
    chk("stall_r2_valid", ov0, 1);
    chk("stall_r2_o", $signed(o0), -5);
    idle();
    chk("stall_drain", ov0, 0);
    chk("stall_acc", $signed(acc0), 1);

    // Reset with two ops in flight
    step(1'b1, 1'b1, 1'b1, 2'b11, 5, 5, 5);
    step(1'b1, 1'b1, 1'b1, 2'b10, 5, 5, 5);
    step(1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("flush_no_valid", ov0, 0);
    end
    chk("flush_acc", $signed(acc0), 0);
    chk("flush_ovf", ovf0, 0);
    step(1'b1, 1'b1, 1'b1, 2'b00, 3, 4, 2);
    idle();
    chk("post_rst_early", ov0, 0);
    idle();
    chk("post_rst_valid", ov0, 1);
    chk("post_rst_o", $signed(o0), 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
